// File: rtl/i2c_xfer_sequencer_pkg.sv
// Shared types for the i2c transaction sequencer: FSM/phase enums, status codes,
// the latched request record and the write-phase payload builder.
package i2c_seq_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT_HI, WAIT_LO, RESP} state_t;
  typedef enum logic [1:0] {WR, PTR, RD} phase_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;
  localparam logic [1:0] ST_BAD  = 2'b11;

  typedef struct packed {
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  mem;
    logic [2:0]  len;
    logic [31:0] wdata;
  } req_t;

  // Pointer byte leads; byte k of wdata lands in the k-th slot, unused slots zero.
  function automatic logic [39:0] wr_payload(input req_t r);
    logic [39:0] d;
    d = {r.mem, 32'h0};
    for (int k = 0; k < 4; k++)
      if (k < int'(r.len)) d[31-8*k -: 8] = r.wdata[8*k +: 8];
    return d;
  endfunction

endpackage

// File: rtl/i2c_xfer_sequencer_if.sv
// Host request/response plus i2c_top control pins, bundled for the sequencer.
interface i2c_xfer_sequencer_if;
  logic        req_valid, req_ready, req_rw;
  logic [6:0]  req_dev;
  logic [7:0]  req_mem;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic [6:0]  addr;
  logic        rw;
  logic [39:0] data_w;
  logic [3:0]  N_byte;
  logic        start;
  logic [7:0]  data_out;
  logic        valid_out, busy, erro_addr;

  modport master (
    input  req_valid, req_rw, req_dev, req_mem, req_len, req_wdata,
           data_out, valid_out, busy, erro_addr,
    output req_ready, rsp_valid, rsp_status, rsp_rdata,
           addr, rw, data_w, N_byte, start
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_mem, req_len, req_wdata,
           data_out, valid_out, busy, erro_addr,
    input  req_ready, rsp_valid, rsp_status, rsp_rdata,
           addr, rw, data_w, N_byte, start
  );
endinterface

// File: rtl/i2c_xfer_sequencer_timer.sv
// Clearable saturating cycle counter; expired stays high once TIMEOUT_CYC is reached.
module i2c_seq_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)    cnt <= '0;
    else if (!expired) cnt <= cnt + W'(1);
  end

  assign expired = (cnt == W'(TIMEOUT_CYC));
endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Memory-style request sequencer in front of i2c_top: write = one transaction,
// read = pointer write then read; address-NACK retry, per-phase timeout, status report.
module i2c_xfer_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic rst,
  i2c_xfer_sequencer_if.master bus
);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  req_t        rq;
  logic [7:0]  retry;
  logic        nack;
  logic [2:0]  cnt, cnt_eff;
  logic [31:0] rdata;
  logic [1:0]  status, status_n;
  logic        in_wait, tmr_clr, tmo, nack_eff, byte_take, relaunch, accept;

  assign in_wait   = (state == WAIT_HI) || (state == WAIT_LO);
  assign accept    = (state == IDLE) && bus.req_valid;
  assign byte_take = (phase == RD) && in_wait && bus.valid_out && (cnt < rq.len);
  assign cnt_eff   = cnt + {2'b00, byte_take};
  // erro_addr in the busy-fall cycle still counts as a NACK for that phase
  assign nack_eff  = nack | (in_wait & bus.erro_addr);
  assign relaunch  = (state == WAIT_LO) && !bus.busy && nack_eff && (int'(retry) < MAX_RETRY);
  assign tmr_clr   = (state == LAUNCH) || ((state == WAIT_HI) && bus.busy);

  i2c_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .expired (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= WR;
      status <= ST_OK;
      rq     <= '0;
      retry  <= '0;
      nack   <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      status <= status_n;
      if (accept) begin
        rq    <= '{rw: bus.req_rw, dev: bus.req_dev, mem: bus.req_mem,
                   len: bus.req_len, wdata: bus.req_wdata};
        rdata <= '0;
        retry <= '0;
      end
      if (relaunch) retry <= retry + 8'd1;
      if (state == LAUNCH) begin
        nack <= 1'b0;
        cnt  <= '0;
      end else if (in_wait && bus.erro_addr) begin
        nack <= 1'b1;
      end
      if (byte_take) begin
        rdata[{cnt[1:0], 3'b000} +: 8] <= bus.data_out;
        cnt <= cnt_eff;
      end
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    status_n = status;
    case (state)
      IDLE:    if (bus.req_valid) begin
                 state_n  = CHECK;
                 status_n = ST_OK;
               end
      CHECK:   if (rq.len == 3'd0 || rq.len > 3'd4) begin
                 state_n  = RESP;
                 status_n = ST_BAD;
               end else begin
                 state_n = LAUNCH;
                 phase_n = rq.rw ? PTR : WR;
               end
      LAUNCH:  state_n = WAIT_HI;
      WAIT_HI: if (bus.busy) state_n = WAIT_LO;
               else if (tmo) begin
                 state_n  = RESP;
                 status_n = ST_TMO;
               end
      WAIT_LO: if (!bus.busy) begin
                 if (nack_eff) begin
                   if (relaunch) state_n = LAUNCH;
                   else begin
                     state_n  = RESP;
                     status_n = ST_NACK;
                   end
                 end else begin
                   case (phase)
                     PTR: begin
                       state_n = LAUNCH;
                       phase_n = RD;
                     end
                     RD: begin
                       state_n  = RESP;
                       status_n = (cnt_eff < rq.len) ? ST_BAD : ST_OK;
                     end
                     default: begin
                       state_n  = RESP;
                       status_n = ST_OK;
                     end
                   endcase
                 end
               end else if (tmo) begin
                 state_n  = RESP;
                 status_n = ST_TMO;
               end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus-side pins are driven only while a phase is in flight, zero otherwise.
  always_comb begin
    bus.addr   = '0;
    bus.rw     = 1'b0;
    bus.data_w = '0;
    bus.N_byte = '0;
    if (state == LAUNCH || in_wait) begin
      bus.addr = rq.dev;
      case (phase)
        WR: begin
          bus.data_w = wr_payload(rq);
          bus.N_byte = {1'b0, rq.len};
        end
        PTR: bus.data_w = {rq.mem, 32'h0};
        default: begin
          bus.rw     = 1'b1;
          bus.data_w = {rq.mem, 32'h0};
          bus.N_byte = {1'b0, rq.len - 3'd1};
        end
      endcase
    end
  end

  assign bus.start      = (state == LAUNCH);
  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_status = status;
  assign bus.rsp_rdata  = rdata;

endmodule
